dlsc_pcie_s6_inbound_read_cpl: RTL and testbench

Completion TLP formatter for the inbound (target) read path. Consumes per-completion descriptors from the read-completion splitter, per-request context (requester ID, tag, TC, attributes, UR flag) from the request side FIFO, and read data DWs from the target read-data path. Emits complete 3DW Cpl/CplD TLPs as a 32-bit stream toward the Spartan-6 PCIe TX arbiter.

---
 rtl/dlsc_pcie_s6_inbound_read_cpl.sv | 200 ++++++++++++++++++++
 tb/tb_dlsc_pcie_s6_inbound_read_cpl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlsc_pcie_s6_inbound_read_cpl.sv
// Builds 3DW Cpl/CplD TLPs for the inbound read path and streams them as 32-bit beats.
// Header fields come straight from the descriptor/context inputs, which must hold until popped.
module dlsc_pcie_s6_inbound_read_cpl #(
  parameter bit REGISTER = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rcb_ready,
  input  logic        rcb_valid,
  input  logic [6:0]  rcb_addr,
  input  logic [9:0]  rcb_len,
  input  logic [11:0] rcb_bytes,
  input  logic        rcb_last,
  output logic        req_ready,
  input  logic        req_valid,
  input  logic [15:0] req_id,
  input  logic [7:0]  req_tag,
  input  logic [2:0]  req_tc,
  input  logic [1:0]  req_attr,
  input  logic        req_ur,
  output logic        rd_ready,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  input  logic [15:0] cfg_completer_id,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  output logic        tx_sof,
  output logic        tx_eof
);

  typedef enum logic [2:0] {IDLE, H0, H1, H2, DATA} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  cnt;
  logic        cnt_load;
  logic        cnt_dec;

  logic        beat_valid;
  logic        beat_ready;
  logic        beat_sof;
  logic        beat_eof;
  logic [31:0] beat_data;

  logic [31:0] dw0;
  logic [31:0] dw1;
  logic [31:0] dw2;

  assign dw0 = {1'b0, (req_ur ? 2'b00 : 2'b10), 5'b01010, 1'b0, req_tc, 4'b0000,
                1'b0, 1'b0, req_attr, 2'b00, (req_ur ? 10'd0 : rcb_len)};
  assign dw1 = {cfg_completer_id, (req_ur ? 3'b001 : 3'b000), 1'b0, rcb_bytes};
  assign dw2 = {req_id, req_tag, 1'b0, rcb_addr};

  // A load of 0 wraps through 1023..1, giving 1024 payload beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 10'd0;
    end else begin
      state <= state_nxt;
      if (cnt_load) begin
        cnt <= rcb_len;
      end else if (cnt_dec) begin
        cnt <= cnt - 10'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    beat_valid = 1'b0;
    beat_sof   = 1'b0;
    beat_eof   = 1'b0;
    beat_data  = 32'd0;
    rcb_ready  = 1'b0;
    req_ready  = 1'b0;
    rd_ready   = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    case (state)
      IDLE: begin
        if (rcb_valid && req_valid) begin
          // Non-final pieces of an unsupported request produce no TLP.
          if (req_ur && !rcb_last) begin
            rcb_ready = 1'b1;
          end else begin
            state_nxt = H0;
          end
        end
      end
      H0: begin
        beat_valid = 1'b1;
        beat_sof   = 1'b1;
        beat_data  = dw0;
        if (beat_ready) begin
          state_nxt = H1;
        end
      end
      H1: begin
        beat_valid = 1'b1;
        beat_data  = dw1;
        if (beat_ready) begin
          state_nxt = H2;
        end
      end
      H2: begin
        beat_valid = 1'b1;
        beat_eof   = req_ur;
        beat_data  = dw2;
        if (beat_ready) begin
          if (req_ur) begin
            state_nxt = IDLE;
            rcb_ready = 1'b1;
            req_ready = rcb_last;
          end else begin
            state_nxt = DATA;
            cnt_load  = 1'b1;
          end
        end
      end
      DATA: begin
        beat_valid = rd_valid;
        beat_eof   = (cnt == 10'd1);
        beat_data  = rd_data;
        rd_ready   = beat_ready;
        if (rd_valid && beat_ready) begin
          cnt_dec = 1'b1;
          if (cnt == 10'd1) begin
            state_nxt = IDLE;
            rcb_ready = 1'b1;
            req_ready = rcb_last;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Nothing may be popped or emitted while reset is held.
    if (!rst_n) begin
      state_nxt  = IDLE;
      beat_valid = 1'b0;
      rcb_ready  = 1'b0;
      req_ready  = 1'b0;
      rd_ready   = 1'b0;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
    end
  end

  generate
    if (REGISTER) begin : g_reg
      logic        out_vld;
      logic        skid_vld;
      logic [33:0] out_q;
      logic [33:0] skid_q;

      assign beat_ready = !skid_vld;

      // Second entry catches the beat accepted in the cycle tx_ready drops.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_vld  <= 1'b0;
          skid_vld <= 1'b0;
          out_q    <= 34'd0;
          skid_q   <= 34'd0;
        end else if (tx_ready || !out_vld) begin
          if (skid_vld) begin
            out_q    <= skid_q;
            out_vld  <= 1'b1;
            skid_vld <= 1'b0;
          end else begin
            out_vld <= beat_valid;
            if (beat_valid) begin
              out_q <= {beat_sof, beat_eof, beat_data};
            end
          end
        end else if (beat_valid && !skid_vld) begin
          skid_q   <= {beat_sof, beat_eof, beat_data};
          skid_vld <= 1'b1;
        end
      end

      assign tx_valid = out_vld;
      assign tx_sof   = out_q[33];
      assign tx_eof   = out_q[32];
      assign tx_data  = out_q[31:0];
    end else begin : g_direct
      assign beat_ready = tx_ready;
      assign tx_valid   = beat_valid;
      assign tx_sof     = beat_sof;
      assign tx_eof     = beat_eof;
      assign tx_data    = beat_data;
    end
  endgenerate

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_read_cpl.sv
// Directed bench for the inbound read completion formatter (REGISTER=1).
module tb_dlsc_pcie_s6_inbound_read_cpl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rcb_ready, rcb_valid, rcb_last;
  logic [6:0]  rcb_addr;
  logic [9:0]  rcb_len;
  logic [11:0] rcb_bytes;
  logic        req_ready, req_valid, req_ur;
  logic [15:0] req_id;
  logic [7:0]  req_tag;
  logic [2:0]  req_tc;
  logic [1:0]  req_attr;
  logic        rd_ready, rd_valid;
  logic [31:0] rd_data;
  logic [15:0] cfg_completer_id;
  logic        tx_ready, tx_valid, tx_sof, tx_eof;
  logic [31:0] tx_data;

  localparam logic [15:0] CID = 16'hBEEF;

  always #5 clk = ~clk;

  dlsc_pcie_s6_inbound_read_cpl #(.REGISTER(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rcb_ready(rcb_ready), .rcb_valid(rcb_valid), .rcb_addr(rcb_addr), .rcb_len(rcb_len),
    .rcb_bytes(rcb_bytes), .rcb_last(rcb_last),
    .req_ready(req_ready), .req_valid(req_valid), .req_id(req_id), .req_tag(req_tag),
    .req_tc(req_tc), .req_attr(req_attr), .req_ur(req_ur),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .cfg_completer_id(cfg_completer_id),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_sof(tx_sof), .tx_eof(tx_eof)
  );

  typedef struct {
    logic [6:0]  addr;
    logic [9:0]  len;
    logic [11:0] bytes;
    logic        last;
  } desc_t;

  desc_t       dq[$];
  logic [33:0] bq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc, first_sof_cyc, last_eof_cyc, rcb_pops, req_pops, req_pop_rcb, stall_bad, rd_idx;
  bit          rd_seen, rnd_tx, rnd_rd, held;
  logic [33:0] hq;
  logic [31:0] rd_base;

  task automatic clear_stats();
    bq.delete();
    cyc = 0; first_sof_cyc = 0; last_eof_cyc = 0; rcb_pops = 0; req_pops = 0;
    req_pop_rcb = 0; stall_bad = 0; rd_idx = 0; rd_seen = 0; held = 0;
  endtask

  task automatic apply_inputs();
    if (dq.size() > 0) begin
      rcb_valid = 1'b1; rcb_addr = dq[0].addr; rcb_len = dq[0].len;
      rcb_bytes = dq[0].bytes; rcb_last = dq[0].last;
    end else begin
      rcb_valid = 1'b0;
    end
    rd_valid = rnd_rd ? 1'($urandom_range(0, 1)) : 1'b1;
    rd_data  = rd_base + 32'(rd_idx);
    tx_ready = rnd_tx ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic start_req(input logic [15:0] id, input logic [7:0] tag, input logic [2:0] tc,
                           input logic [1:0] attr, input logic ur);
    req_valid = 1'b1; req_id = id; req_tag = tag; req_tc = tc; req_attr = attr; req_ur = ur;
    apply_inputs();
  endtask

  // One clock: sample at the falling edge, update stimulus just after the rising edge.
  task automatic step();
    bit p_rcb, p_req, p_rd;
    @(negedge clk);
    cyc++;
    if (held && (!tx_valid || {tx_sof, tx_eof, tx_data} !== hq)) stall_bad++;
    held = tx_valid && !tx_ready;
    hq   = {tx_sof, tx_eof, tx_data};
    if (tx_valid && tx_ready) begin
      bq.push_back({tx_sof, tx_eof, tx_data});
      if (tx_sof && first_sof_cyc == 0) first_sof_cyc = cyc;
      if (tx_eof) last_eof_cyc = cyc;
    end
    p_rcb = rcb_ready;
    p_req = req_ready;
    p_rd  = rd_valid && rd_ready;
    if (rcb_ready) rcb_pops++;
    if (req_ready) begin req_pops++; req_pop_rcb = rcb_pops; end
    if (rd_ready) rd_seen = 1'b1;
    @(posedge clk);
    #1;
    if (p_rcb && dq.size() > 0) dq.delete(0);
    if (p_req) req_valid = 1'b0;
    if (p_rd) rd_idx++;
    apply_inputs();
  endtask

  task automatic run_beats(input int n, input int budget);
    int g = 0;
    while (bq.size() < n && g < budget) begin step(); g++; end
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rcb_valid = 0; rcb_addr = 0; rcb_len = 0; rcb_bytes = 0; rcb_last = 0;
    req_valid = 0; req_id = 0; req_tag = 0; req_tc = 0; req_attr = 0; req_ur = 0;
    rd_valid = 0; rd_data = 0; cfg_completer_id = CID; tx_ready = 1'b1;
    rnd_tx = 0; rnd_rd = 0; rd_base = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b exp 0", tx_valid); end
    tests++; if (tx_data !== 32'd0) begin fails++; $display("FAIL reset_tx_data: got %h exp 0", tx_data); end
    tests++; if (tx_sof !== 1'b0 || tx_eof !== 1'b0) begin fails++; $display("FAIL reset_sof_eof: got %b%b exp 00", tx_sof, tx_eof); end
    tests++; if ({rcb_ready, req_ready, rd_ready} !== 3'b000) begin fails++; $display("FAIL reset_pops: got %b exp 000", {rcb_ready, req_ready, rd_ready}); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    clear_stats();
    rd_base = 32'hA5A5_0000;
    dq.push_back('{7'h05, 10'd1, 12'd3, 1'b1});
    start_req(16'h0100, 8'h2A, 3'd0, 2'd0, 1'b0);
    run_beats(4, 40);
    tests++; if (bq.size() != 4) begin fails++; $display("FAIL single_beats: got %0d exp 4", bq.size()); end
    if (bq.size() >= 4) begin
      tests++; if (bq[0] !== {2'b10, 32'h4A000001}) begin fails++; $display("FAIL single_dw0: got %h exp %h", bq[0], {2'b10, 32'h4A000001}); end
      tests++; if (bq[1] !== {2'b00, CID, 16'h0003}) begin fails++; $display("FAIL single_dw1: got %h exp %h", bq[1], {2'b00, CID, 16'h0003}); end
      tests++; if (bq[2] !== {2'b00, 32'h01002A05}) begin fails++; $display("FAIL single_dw2: got %h exp %h", bq[2], {2'b00, 32'h01002A05}); end
      tests++; if (bq[3] !== {2'b01, 32'hA5A50000}) begin fails++; $display("FAIL single_data: got %h exp %h", bq[3], {2'b01, 32'hA5A50000}); end
    end
    tests++; if (first_sof_cyc != 3) begin fails++; $display("FAIL single_latency: got %0d exp 3", first_sof_cyc); end
    tests++; if (last_eof_cyc != 6) begin fails++; $display("FAIL single_eof_cycle: got %0d exp 6", last_eof_cyc); end
    tests++; if (rcb_pops != 1 || req_pops != 1) begin fails++; $display("FAIL single_pops: got rcb %0d req %0d exp 1 1", rcb_pops, req_pops); end
  endtask

  task automatic test_split();
    int bad = 0;
    logic [33:0] e;
    clear_stats();
    rd_base = 32'hC000_0000;
    dq.push_back('{7'h40, 10'd32, 12'd256, 1'b0});
    dq.push_back('{7'h00, 10'd32, 12'd128, 1'b1});
    start_req(16'h1234, 8'h07, 3'd2, 2'b01, 1'b0);
    run_beats(70, 200);
    tests++; if (bq.size() != 70) begin fails++; $display("FAIL split_beats: got %0d exp 70", bq.size()); end
    if (bq.size() == 70) begin
      tests++; if (bq[0] !== {2'b10, 32'h4A201020}) begin fails++; $display("FAIL split_dw0a: got %h exp %h", bq[0], {2'b10, 32'h4A201020}); end
      tests++; if (bq[1] !== {2'b00, CID, 16'h0100}) begin fails++; $display("FAIL split_dw1a: got %h exp %h", bq[1], {2'b00, CID, 16'h0100}); end
      tests++; if (bq[2] !== {2'b00, 32'h12340740}) begin fails++; $display("FAIL split_dw2a: got %h exp %h", bq[2], {2'b00, 32'h12340740}); end
      tests++; if (bq[35] !== {2'b10, 32'h4A201020}) begin fails++; $display("FAIL split_dw0b: got %h exp %h", bq[35], {2'b10, 32'h4A201020}); end
      tests++; if (bq[36] !== {2'b00, CID, 16'h0080}) begin fails++; $display("FAIL split_dw1b: got %h exp %h", bq[36], {2'b00, CID, 16'h0080}); end
      tests++; if (bq[37] !== {2'b00, 32'h12340700}) begin fails++; $display("FAIL split_dw2b: got %h exp %h", bq[37], {2'b00, 32'h12340700}); end
      for (int i = 0; i < 70; i++) begin
        if (i >= 3 && i < 35) e = {1'b0, (i == 34), rd_base + 32'(i - 3)};
        else if (i >= 38) e = {1'b0, (i == 69), rd_base + 32'(i - 6)};
        else e = {(i == 0 || i == 35), 1'b0, bq[i][31:0]};
        if (bq[i] !== e) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL split_payload: got %0d bad beats exp 0", bad); end
    end
    tests++; if (rcb_pops != 2 || req_pops != 1) begin fails++; $display("FAIL split_pops: got rcb %0d req %0d exp 2 1", rcb_pops, req_pops); end
    tests++; if (req_pop_rcb != 2) begin fails++; $display("FAIL split_req_pop_timing: got %0d exp 2", req_pop_rcb); end
    tests++; if (last_eof_cyc != 73) begin fails++; $display("FAIL split_throughput: got %0d exp 73", last_eof_cyc); end
  endtask

  task automatic test_ur();
    clear_stats();
    rd_base = 32'hD000_0000;
    dq.push_back('{7'h10, 10'd1, 12'd8, 1'b0});
    dq.push_back('{7'h00, 10'd1, 12'd4, 1'b1});
    start_req(16'hABCD, 8'h11, 3'd0, 2'd0, 1'b1);
    run_beats(3, 40);
    tests++; if (bq.size() != 3) begin fails++; $display("FAIL ur_beats: got %0d exp 3", bq.size()); end
    if (bq.size() == 3) begin
      tests++; if (bq[0] !== {2'b10, 32'h0A000000}) begin fails++; $display("FAIL ur_dw0: got %h exp %h", bq[0], {2'b10, 32'h0A000000}); end
      tests++; if (bq[1] !== {2'b00, CID, 16'h2004}) begin fails++; $display("FAIL ur_dw1: got %h exp %h", bq[1], {2'b00, CID, 16'h2004}); end
      tests++; if (bq[2] !== {2'b01, 32'hABCD1100}) begin fails++; $display("FAIL ur_dw2: got %h exp %h", bq[2], {2'b01, 32'hABCD1100}); end
    end
    tests++; if (rd_seen !== 1'b0) begin fails++; $display("FAIL ur_rd_ready: got %b exp 0", rd_seen); end
    tests++; if (rcb_pops != 2 || req_pops != 1) begin fails++; $display("FAIL ur_pops: got rcb %0d req %0d exp 2 1", rcb_pops, req_pops); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    logic [33:0] e;
    clear_stats();
    rd_base = 32'h5000_0000;
    rnd_tx = 1'b1; rnd_rd = 1'b1;
    dq.push_back('{7'h0C, 10'd16, 12'd64, 1'b1});
    start_req(16'h0200, 8'h33, 3'd0, 2'd0, 1'b0);
    run_beats(19, 400);
    rnd_tx = 1'b0; rnd_rd = 1'b0;
    tests++; if (bq.size() != 19) begin fails++; $display("FAIL bp_beats: got %0d exp 19", bq.size()); end
    if (bq.size() == 19) begin
      tests++; if (bq[0] !== {2'b10, 32'h4A000010}) begin fails++; $display("FAIL bp_dw0: got %h exp %h", bq[0], {2'b10, 32'h4A000010}); end
      for (int i = 3; i < 19; i++) begin
        e = {1'b0, (i == 18), rd_base + 32'(i - 3)};
        if (bq[i] !== e) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL bp_payload: got %0d bad beats exp 0", bad); end
    end
    tests++; if (stall_bad != 0) begin fails++; $display("FAIL bp_stable: got %0d unstable stalls exp 0", stall_bad); end
  endtask

  task automatic test_max_len();
    int bad = 0;
    logic [33:0] e;
    clear_stats();
    rd_base = 32'h7000_0000;
    dq.push_back('{7'h00, 10'd0, 12'd0, 1'b1});
    start_req(16'h0300, 8'h44, 3'd0, 2'd0, 1'b0);
    run_beats(1027, 1300);
    tests++; if (bq.size() != 1027) begin fails++; $display("FAIL max_beats: got %0d exp 1027", bq.size()); end
    if (bq.size() == 1027) begin
      tests++; if (bq[0] !== {2'b10, 32'h4A000000}) begin fails++; $display("FAIL max_dw0: got %h exp %h", bq[0], {2'b10, 32'h4A000000}); end
      tests++; if (bq[1] !== {2'b00, CID, 16'h0000}) begin fails++; $display("FAIL max_dw1: got %h exp %h", bq[1], {2'b00, CID, 16'h0000}); end
      for (int i = 3; i < 1027; i++) begin
        e = {1'b0, (i == 1026), rd_base + 32'(i - 3)};
        if (bq[i] !== e) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL max_payload: got %0d bad beats exp 0", bad); end
    end
    tests++; if (rcb_pops != 1 || req_pops != 1) begin fails++; $display("FAIL max_pops: got rcb %0d req %0d exp 1 1", rcb_pops, req_pops); end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    clear_stats();
    rd_base = 32'h9000_0000;
    dq.push_back('{7'h00, 10'd8, 12'd32, 1'b1});
    start_req(16'h0400, 8'h55, 3'd0, 2'd0, 1'b0);
    while (bq.size() < 8 && g < 100) begin step(); g++; end
    tests++; if (bq.size() != 8) begin fails++; $display("FAIL rstmid_progress: got %0d exp 8", bq.size()); end
    rst_n = 1'b0;
    step();
    tests++; if ({tx_valid, tx_sof, tx_eof} !== 3'b000) begin fails++; $display("FAIL rstmid_flags: got %b exp 000", {tx_valid, tx_sof, tx_eof}); end
    tests++; if (tx_data !== 32'd0) begin fails++; $display("FAIL rstmid_data: got %h exp 0", tx_data); end
    tests++; if ({rcb_ready, req_ready, rd_ready} !== 3'b000) begin fails++; $display("FAIL rstmid_ready: got %b exp 000", {rcb_ready, req_ready, rd_ready}); end
    tests++; if (rcb_pops != 0 || req_pops != 0) begin fails++; $display("FAIL rstmid_pops: got rcb %0d req %0d exp 0 0", rcb_pops, req_pops); end
    rst_n = 1'b1;
    clear_stats();
    dq.delete();
    dq.push_back('{7'h08, 10'd2, 12'd8, 1'b1});
    start_req(16'h0500, 8'h66, 3'd0, 2'd0, 1'b0);
    run_beats(5, 40);
    tests++; if (bq.size() != 5) begin fails++; $display("FAIL rstmid_new_beats: got %0d exp 5", bq.size()); end
    if (bq.size() == 5) begin
      tests++; if (bq[0] !== {2'b10, 32'h4A000002}) begin fails++; $display("FAIL rstmid_new_dw0: got %h exp %h", bq[0], {2'b10, 32'h4A000002}); end
      tests++; if (bq[2] !== {2'b00, 32'h05006608}) begin fails++; $display("FAIL rstmid_new_dw2: got %h exp %h", bq[2], {2'b00, 32'h05006608}); end
      tests++; if (bq[4][33:32] !== 2'b01) begin fails++; $display("FAIL rstmid_new_eof: got %b exp 01", bq[4][33:32]); end
    end
    tests++; if (first_sof_cyc != 3) begin fails++; $display("FAIL rstmid_new_latency: got %0d exp 3", first_sof_cyc); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_ur();
    test_backpressure();
    test_max_len();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
